ex_div: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage. It consumes the operands and divide opcode that EX receives from the ID/EX pipeline register and returns a 64-bit {remainder, quotient} result after a fixed iteration count. The EX stage holds `start_i` and stalls the pipeline until `ready_o` is high. The EX stage asserts `annul_i` when a flush cancels the instruction in flight.

---
 rtl/ex_div_if.sv | 24 ++
 rtl/ex_div.sv | 147 ++++++++++++++
 tb/tb_ex_div.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Handshake and data bundle between the EX stage and its multi-cycle divider.
// Latency: n/a (wires only). Backpressure: EX holds start_i until ready_o.
// Ports: master = EX stage (drives request/operands), slave = divider (drives result).
interface ex_div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring divider, signed/unsigned, result = {remainder, quotient}.
// Latency: ready_o rises on the 34th edge counting the start edge (2nd for divide-by-zero).
// Backpressure: result and ready_o hold while start_i stays high; dropping start_i releases.
// Ports: clk, rst (async, active-high); div_if (slave) carries operands, start_i,
//        annul_i, signed_div_i in and registered result_o/ready_o out.
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  div_if
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {FREE, DIVZERO, ON, END} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
  logic [DATA_W-1:0]   dq_q, dq_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                sgn_mode_q, sgn_mode_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     partial, diff;
  logic [DATA_W-1:0]   quot_fin, rem_fin;

  always_comb begin
    op1_neg  = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
    op2_neg  = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
    mag1     = op1_neg ? (~div_if.opdata1_i + 1'b1) : div_if.opdata1_i;
    mag2     = op2_neg ? (~div_if.opdata2_i + 1'b1) : div_if.opdata2_i;
    // 33-bit trial subtraction: the carry-out bit is the "negative" flag.
    partial  = {rem_q, dq_q[DATA_W-1]};
    diff     = partial - {1'b0, dvs_q};
    quot_fin = (sgn_mode_q & (neg1_q ^ neg2_q)) ? (~dq_q + 1'b1) : dq_q;
    rem_fin  = (sgn_mode_q & neg1_q) ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dq_d       = dq_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    sgn_mode_d = sgn_mode_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (div_if.start_i && !div_if.annul_i) begin
          if (div_if.opdata2_i == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d    = ON;
            cnt_d      = '0;
            dq_d       = mag1;
            rem_d      = '0;
            dvs_d      = mag2;
            sgn_mode_d = div_if.signed_div_i;
            neg1_d     = op1_neg;
            neg2_d     = op2_neg;
          end
        end
      end
      DIVZERO: begin
        if (div_if.annul_i) begin
          state_d = FREE;
        end else begin
          state_d  = END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (div_if.annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
          cnt_d    = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            dq_d  = {dq_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = partial[DATA_W-1:0];
            dq_d  = {dq_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = END;
          result_d = {rem_fin, quot_fin};
          ready_d  = 1'b1;
        end
      end
      END: begin
        // annul is deliberately ignored here: the result is already committed.
        if (!div_if.start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      dq_q       <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      sgn_mode_q <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dq_q       <= dq_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      sgn_mode_q <= sgn_mode_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div.
// Drives requests one edge apart from sampling; all expectations are hand-computed.
// Ports: instantiates ex_div_if and ex_div; clock period 10.
module tb_ex_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ex_div_if #(.DATA_W(32)) dif ();

  ex_div #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Full request: start, scramble operands after the start edge, wait for ready,
  // check latency/result, hold one cycle, release and check the clear.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    dif.signed_div_i = sgn; dif.opdata1_i = a; dif.opdata2_i = b; dif.start_i = 1'b1;
    @(posedge clk); #1;  // E0 sampled
    dif.opdata1_i = 32'hDEADBEEF; dif.opdata2_i = 32'h0000_0003; dif.signed_div_i = ~sgn;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (dif.ready_o) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, dif.result_o, exp_res);
    @(posedge clk); #1;
    check({tag, " hold ready"}, 64'(dif.ready_o), 64'd1);
    check({tag, " hold result"}, dif.result_o, exp_res);
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " release ready"}, 64'(dif.ready_o), 64'd0);
    check({tag, " release result"}, dif.result_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit seen_ready;
    int lat;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    #2;
    check("reset ready", 64'(dif.ready_o), 64'd0);
    check("reset result", dif.result_o, 64'd0);
    #10 rst = 1'b0;

    run_div("u100/7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
    run_div("s-100/7",  1'b1, 32'hFFFFFF9C,  32'd7,         64'hFFFFFFFE_FFFFFFF2, 33);
    run_div("s100/-7",  1'b1, 32'd100,       32'hFFFFFFF9,  64'h00000002_FFFFFFF2, 33);
    run_div("s-100/-7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33);
    run_div("uFFFFFF9C/7", 1'b0, 32'hFFFFFF9C, 32'd7,       64'h00000002_24924916, 33);
    run_div("divzero",  1'b0, 32'h12345678,  32'h0,         64'h0, 1);
    run_div("overflow", 1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33);
    run_div("umax/16",  1'b0, 32'hFFFFFFFF,  32'h00000010,  64'h0000000F_0FFFFFFF, 33);

    // Annul at E10, then a 9/2 request sampled at E11.
    seen_ready = 1'b0;
    @(posedge clk); #1;
    dif.signed_div_i = 1'b0; dif.opdata1_i = 32'd100; dif.opdata2_i = 32'd7; dif.start_i = 1'b1;
    @(posedge clk); #1;  // E0
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (dif.ready_o) seen_ready = 1'b1;
    end
    dif.annul_i = 1'b1;
    @(posedge clk); #1;  // E10
    dif.annul_i = 1'b0; dif.opdata1_i = 32'd9; dif.opdata2_i = 32'd2;
    check("annul ready low", 64'(dif.ready_o), 64'd0);
    check("annul result zero", dif.result_o, 64'd0);
    check("annul never ready", 64'(seen_ready), 64'd0);
    @(posedge clk); #1;  // E11 = new E0
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (dif.ready_o) begin
        lat = i;
        break;
      end
    end
    check("after annul latency", 64'(lat), 64'd33);
    check("after annul 9/2", dif.result_o, 64'h00000001_00000004);
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check("after annul release", 64'(dif.ready_o), 64'd0);

    // Async reset mid-operation (between E20 and E21).
    @(posedge clk); #1;
    dif.opdata1_i = 32'd100; dif.opdata2_i = 32'd7; dif.start_i = 1'b1;
    @(posedge clk);  // E0
    for (int i = 1; i <= 20; i++) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst mid-op ready", 64'(dif.ready_o), 64'd0);
    check("rst mid-op result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    @(negedge clk) rst = 1'b0;

    // Async reset while holding a finished result in END.
    @(posedge clk); #1;
    dif.opdata1_i = 32'd9; dif.opdata2_i = 32'd2; dif.start_i = 1'b1;
    lat = 0;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk); #1;
      if (dif.ready_o) begin
        lat = i;
        break;
      end
    end
    check("pre-rst END latency", 64'(lat), 64'd33);
    check("pre-rst END result", dif.result_o, 64'h00000001_00000004);
    #2 rst = 1'b1;
    #1;
    check("rst in END ready", 64'(dif.ready_o), 64'd0);
    check("rst in END result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    @(negedge clk) rst = 1'b0;

    run_div("post-rst u9/2", 1'b0, 32'd9, 32'd2, 64'h00000001_00000004, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
